// File: rtl/column_move_sorter.sv
// Column move sorter: round-robin intake from eight square units into a buffer kept
// sorted by MVV-LVA score; the best move streams out and done flags an exhausted column.
module column_move_sorter #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned MOVE_W = 18
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      flush_i,
   input  logic [7:0]                sq_valid_i,
   input  logic [8*MOVE_W-1:0]       sq_move_i,
   output logic [7:0]                sq_ready_o,
   input  logic [7:0]                sq_done_i,
   output logic                      out_valid_o,
   output logic [MOVE_W-1:0]         out_move_o,
   output logic [5:0]                out_score_o,
   input  logic                      out_ready_i,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      done_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [MOVE_W-1:0] mem_q [DEPTH];
   logic [MOVE_W-1:0] mem_d [DEPTH];
   logic [MOVE_W-1:0] sh_m  [DEPTH];
   logic [5:0]        scr_q [DEPTH];
   logic [5:0]        scr_d [DEPTH];
   logic [5:0]        sh_s  [DEPTH];
   logic [CW-1:0]     count_q, count_d, cnt_pop, ins;
   logic [2:0]        ptr_q, ptr_d, grant_idx, idx;
   logic              valid_q, done_q, done_d;
   logic              grant_found, pop, push, space, clr;
   logic [MOVE_W-1:0] new_mv;
   logic [5:0]        new_scr;

   function automatic logic [5:0] score_of(input logic [MOVE_W-1:0] m);
      return {m[MOVE_W-1 -: 3], 3'd7 - m[MOVE_W-4 -: 3]};
   endfunction

   assign clr     = reset_i | flush_i;
   assign pop     = valid_q & out_ready_i & ~clr;
   assign space   = (count_q < CW'(DEPTH)) | pop;
   assign push    = grant_found & space & ~clr;
   assign new_mv  = sq_move_i[grant_idx*MOVE_W +: MOVE_W];
   assign new_scr = score_of(new_mv);

   // Search starts at the row after the last grant.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr_q;
      idx         = ptr_q;
      for (int k = 0; k < 8; k++) begin
         idx = ptr_q + 3'(k);
         if (!grant_found && sq_valid_i[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   assign sq_ready_o = push ? (8'd1 << grant_idx) : 8'd0;

   // Pop shifts first; the new move then lands after every entry of equal or higher score.
   always_comb begin
      cnt_pop = count_q - CW'(pop);
      ins     = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!pop) begin
            sh_m[i] = mem_q[i];
            sh_s[i] = scr_q[i];
         end else if (i < int'(DEPTH) - 1) begin
            sh_m[i] = mem_q[(i + 1) % DEPTH];
            sh_s[i] = scr_q[(i + 1) % DEPTH];
         end else begin
            sh_m[i] = '0;
            sh_s[i] = '0;
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (CW'(i) < cnt_pop && sh_s[i] >= new_scr) ins = CW'(i + 1);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!push || CW'(i) < ins) begin
            mem_d[i] = sh_m[i];
            scr_d[i] = sh_s[i];
         end else if (CW'(i) == ins) begin
            mem_d[i] = new_mv;
            scr_d[i] = new_scr;
         end else begin
            mem_d[i] = sh_m[(i + DEPTH - 1) % DEPTH];
            scr_d[i] = sh_s[(i + DEPTH - 1) % DEPTH];
         end
      end
      count_d = count_q + CW'(push) - CW'(pop);
      ptr_d   = push ? grant_idx + 3'd1 : ptr_q;
   end

   always_comb begin
      done_d = done_q;
      if (|sq_valid_i)                                     done_d = 1'b0;
      else if (&sq_done_i && count_q == '0 && !push)      done_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
            scr_q[i] <= '0;
         end
         count_q <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
            scr_q[i] <= scr_d[i];
         end
         count_q <= count_d;
         valid_q <= (count_d != '0);
         ptr_q   <= ptr_d;
         done_q  <= done_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_move_o  = mem_q[0];
   assign out_score_o = scr_q[0];
   assign count_o     = count_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_column_move_sorter.sv
// Directed bench for column_move_sorter; expected pops are queued by the stimulus and
// compared by an independent monitor whenever the sorter hands a move out.
module tb_column_move_sorter;

   localparam int DEPTH  = 16;
   localparam int MOVE_W = 18;

   logic                clk = 1'b0;
   logic                reset, flush, out_ready, out_valid, done;
   logic [7:0]          sq_valid, sq_ready, sq_done;
   logic [8*MOVE_W-1:0] sq_move;
   logic [MOVE_W-1:0]   out_move;
   logic [5:0]          out_score;
   logic [4:0]          count;

   typedef struct {
      logic [MOVE_W-1:0] mv;
      logic [5:0]        sc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   logic [MOVE_W-1:0] q_pawn, pxq, qxp, r1m, r4m, r8m, cap, m5, m6;
   logic [MOVE_W-1:0] fill [16];
   logic [7:0]        grants [6];

   always #5 clk = ~clk;

   column_move_sorter #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .sq_valid_i  (sq_valid),
      .sq_move_i   (sq_move),
      .sq_ready_o  (sq_ready),
      .sq_done_i   (sq_done),
      .out_valid_o (out_valid),
      .out_move_o  (out_move),
      .out_score_o (out_score),
      .out_ready_i (out_ready),
      .count_o     (count),
      .done_o      (done)
   );

   function automatic logic [MOVE_W-1:0] mk(input logic [2:0] v, input logic [2:0] a,
                                            input logic [2:0] fx, input logic [2:0] fy,
                                            input logic [2:0] tx, input logic [2:0] ty);
      return {v, a, fx, fy, tx, ty};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic offer(input int row, input logic [MOVE_W-1:0] mv);
      sq_valid = 8'(1 << (row - 1));
      sq_move[(row-1)*MOVE_W +: MOVE_W] = mv;
   endtask

   task automatic expect_pop(input logic [MOVE_W-1:0] mv, input logic [5:0] sc);
      exp_t e;
      e.mv = mv;
      e.sc = sc;
      exp_q.push_back(e);
   endtask

   // Monitor: every accepted output move must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pop: got %0h, expected no pop", out_move);
         end else begin
            mon_e = exp_q.pop_front();
            check("pop_move", 32'(out_move), 32'(mon_e.mv));
            check("pop_score", 32'(out_score), 32'(mon_e.sc));
         end
      end
   end

   initial begin
      q_pawn = mk(3'd0, 3'd1, 3'd4, 3'd1, 3'd4, 3'd3);
      pxq    = mk(3'd5, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4);
      qxp    = mk(3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd6);
      r1m    = mk(3'd2, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2);
      r4m    = mk(3'd1, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5);
      r8m    = mk(3'd4, 3'd6, 3'd7, 3'd7, 3'd6, 3'd6);
      cap    = mk(3'd4, 3'd2, 3'd3, 3'd3, 3'd5, 3'd5);
      m5     = mk(3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3);
      m6     = mk(3'd3, 3'd3, 3'd6, 3'd6, 3'd6, 3'd5);
      for (int i = 0; i < 16; i++) fill[i] = mk(3'd0, 3'd1, 3'd1, 3'd1, 3'(i >> 3), 3'(i & 7));
      grants[0] = 8'b0000_0001; grants[1] = 8'b0000_1000; grants[2] = 8'b1000_0000;
      grants[3] = 8'b0000_0001; grants[4] = 8'b0000_1000; grants[5] = 8'b1000_0000;

      reset = 1'b1; flush = 1'b0; sq_valid = '0; sq_move = '0; sq_done = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      mid();
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_move", 32'(out_move), 32'd0);
      check("rst_out_score", 32'(out_score), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sq_ready", 32'(sq_ready), 32'd0);

      // Single quiet pawn move from row 3.
      tick();
      offer(3, q_pawn);
      mid();
      check("t1_ready", 32'(sq_ready), 32'b0000_0100);
      tick();
      sq_valid = '0;
      mid();
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_score", 32'(out_score), 32'd6);
      check("t1_count", 32'(count), 32'd1);
      check("t1_out_move", 32'(out_move), 32'(q_pawn));

      // Captures outrank the quiet move; pops come out 46, 10, 6.
      tick();
      offer(5, pxq);
      tick();
      offer(2, qxp);
      tick();
      sq_valid = '0;
      mid();
      check("t2_top_score", 32'(out_score), 32'd46);
      check("t2_count", 32'(count), 32'd3);
      expect_pop(pxq, 6'd46);
      expect_pop(qxp, 6'd10);
      expect_pop(q_pawn, 6'd6);
      tick();
      out_ready = 1'b1;
      tick(); tick(); tick();
      out_ready = 1'b0;
      mid();
      check("t2_drained", 32'(count), 32'd0);
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Flush resets the pointer; rows 1, 4, 8 then take turns.
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int r = 0; r < 2; r++) begin
         expect_pop(r1m, 6'd22);
         expect_pop(r4m, 6'd11);
         expect_pop(r8m, 6'd33);
      end
      out_ready = 1'b1;
      sq_valid = 8'b1000_1001;
      sq_move[0*MOVE_W +: MOVE_W] = r1m;
      sq_move[3*MOVE_W +: MOVE_W] = r4m;
      sq_move[7*MOVE_W +: MOVE_W] = r8m;
      for (int i = 0; i < 6; i++) begin
         mid();
         check($sformatf("t3_grant%0d", i), 32'(sq_ready), 32'(grants[i]));
         tick();
      end
      sq_valid = '0;
      tick(); tick();
      out_ready = 1'b0;
      mid();
      check("t3_drained", 32'(count), 32'd0);
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Fill to DEPTH, then a simultaneous pop and push at full.
      tick();
      expect_pop(fill[0], 6'd6);
      expect_pop(cap, 6'd37);
      for (int i = 1; i < 16; i++) expect_pop(fill[i], 6'd6);
      for (int i = 0; i < 16; i++) begin
         offer(2, fill[i]);
         tick();
      end
      offer(2, cap);
      mid();
      check("t4_full_no_grant", 32'(sq_ready), 32'd0);
      check("t4_full_count", 32'(count), 32'd16);
      tick();
      out_ready = 1'b1;
      mid();
      check("t4_grant_on_pop", 32'(sq_ready), 32'b0000_0010);
      tick();
      sq_valid = '0;
      mid();
      check("t4_count_held", 32'(count), 32'd16);
      check("t4_new_top", 32'(out_score), 32'd37);
      for (int i = 0; i < 16; i++) tick();
      out_ready = 1'b0;
      mid();
      check("t4_drained", 32'(count), 32'd0);
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // Equal-score captures from rows 5 and 6 leave in arrival order.
      tick();
      sq_valid = 8'b0011_0000;
      sq_move[4*MOVE_W +: MOVE_W] = m5;
      sq_move[5*MOVE_W +: MOVE_W] = m6;
      mid();
      check("t5_grant_row5", 32'(sq_ready), 32'b0001_0000);
      tick();
      mid();
      check("t5_grant_row6", 32'(sq_ready), 32'b0010_0000);
      tick();
      sq_valid = '0;
      expect_pop(m5, 6'd28);
      expect_pop(m6, 6'd28);
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      mid();
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // Flush beats push and pop; done follows once everything is idle.
      tick();
      for (int i = 0; i < 5; i++) begin
         offer(7, mk(3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'(i)));
         tick();
      end
      sq_valid = '0;
      mid();
      check("t6_count5", 32'(count), 32'd5);
      tick();
      flush = 1'b1;
      offer(1, q_pawn);
      out_ready = 1'b1;
      mid();
      check("t6_flush_no_grant", 32'(sq_ready), 32'd0);
      tick();
      flush = 1'b0;
      sq_valid = '0;
      out_ready = 1'b0;
      mid();
      check("t6_count0", 32'(count), 32'd0);
      check("t6_out_valid0", 32'(out_valid), 32'd0);
      tick();
      sq_done = 8'hFF;
      mid();
      check("t6_done_not_yet", 32'(done), 32'd0);
      tick();
      mid();
      check("t6_done_set", 32'(done), 32'd1);
      tick();
      offer(1, q_pawn);
      mid();
      check("t6_done_held", 32'(done), 32'd1);
      tick();
      sq_valid = '0;
      mid();
      check("t6_done_cleared", 32'(done), 32'd0);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
